// File: rtl/apb_master.sv
// APB master: queues read/write commands in a small FIFO and plays them out one at a
// time as APB transfers, returning one response per command with timeout protection.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic                  fifoWrite_q [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifoAddr_q  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifoData_q  [CMD_DEPTH];
  logic [PTR_W:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W:0]        rdPtr_q, rdPtr_d;
  logic                  fifoFull, fifoEmpty, push, pop;

  logic [CNT_W-1:0]      waitCnt_q, waitCnt_d;
  logic                  timeoutHit;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;
  logic                  rspErr_q, rspErr_d;
  logic                  rspTimeout_q, rspTimeout_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign cmd_ready = !fifoFull;
  assign push      = cmd_valid && !fifoFull;
  assign pop       = (state_q == IDLE) && !fifoEmpty;
  assign wrPtr_d   = push ? wrPtr_q + (PTR_W+1)'(1) : wrPtr_q;
  assign rdPtr_d   = pop  ? rdPtr_q + (PTR_W+1)'(1) : rdPtr_q;

  assign timeoutHit = !PREADY && (waitCnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (push) begin
      fifoWrite_q[wrPtr_q[PTR_W-1:0]] <= cmd_write;
      fifoAddr_q[wrPtr_q[PTR_W-1:0]]  <= cmd_addr;
      fifoData_q[wrPtr_q[PTR_W-1:0]]  <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      waitCnt_q    <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      waitCnt_q    <= waitCnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      rspTimeout_q <= rspTimeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifoEmpty) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeoutHit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB signals and the response are registered; these are their next values.
  always_comb begin
    waitCnt_d    = waitCnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rspValid_d   = rspValid_q;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    rspTimeout_d = rspTimeout_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (!fifoEmpty) begin
          psel_d   = 1'b1;
          pwrite_d = fifoWrite_q[rdPtr_q[PTR_W-1:0]];
          paddr_d  = fifoAddr_q[rdPtr_q[PTR_W-1:0]];
          pwdata_d = fifoData_q[rdPtr_q[PTR_W-1:0]];
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        waitCnt_d = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          rspRdata_d   = (pwrite_q || PSLVERR) ? '0 : PRDATA;
          rspErr_d     = PSLVERR;
          rspTimeout_d = 1'b0;
          rspValid_d   = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
        end else if (timeoutHit) begin
          rspRdata_d   = '0;
          rspErr_d     = 1'b1;
          rspTimeout_d = 1'b1;
          rspValid_d   = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) rspValid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = rspRdata_q;
  assign rsp_err     = rspErr_q;
  assign rsp_timeout = rspTimeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized bench for apb_master: a behavioural APB slave with 1024-word
// memory plus an in-order response model that predicts every response from command rules.
module tb_apb_master;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MEMSZ = 1024;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural slave: programmable wait states, error beyond memory, optional hang.
  logic [DW-1:0] slaveMem [MEMSZ];
  logic          memLoad = 1'b1;
  logic          hangMode = 1'b0;
  int            slaveWaits = 0;
  int            accCnt = 0;

  assign PREADY  = PSEL && PENABLE && !hangMode && (accCnt >= slaveWaits);
  assign PSLVERR = PSEL && PENABLE && (PADDR >= AW'(MEMSZ));
  assign PRDATA  = (PADDR < AW'(MEMSZ)) ? slaveMem[PADDR[9:0]] : 32'hBAD0BAD0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) accCnt <= accCnt + 1;
    else accCnt <= 0;
    if (memLoad) begin
      for (int i = 0; i < MEMSZ; i++) slaveMem[i] <= DW'(i);
    end else if (PSEL && PENABLE && PREADY && PWRITE && (PADDR < AW'(MEMSZ))) begin
      slaveMem[PADDR[9:0]] <= PWDATA;
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t          expQ[$];
  logic [DW-1:0] refMem [MEMSZ];

  function automatic void modelPush(logic wr, logic [AW-1:0] addr, logic [DW-1:0] data);
    rsp_t r;
    r.rdata = '0;
    r.err   = 1'b0;
    r.tmo   = 1'b0;
    if (hangMode) begin
      r.err = 1'b1;
      r.tmo = 1'b1;
    end else if (addr >= AW'(MEMSZ)) begin
      r.err = 1'b1;
    end else if (wr) begin
      refMem[addr[9:0]] = data;
    end else begin
      r.rdata = refMem[addr[9:0]];
    end
    expQ.push_back(r);
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic wr, logic [AW-1:0] addr, logic [DW-1:0] data);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput("cmd_ready_wait", 64'(n < 200), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    modelPush(wr, addr, data);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic collectResponse(string tag, output int edges, output int accessCycles,
                                 output logic sawSetup, output logic [DW-1:0] rdata);
    rsp_t e;
    edges = 1;
    accessCycles = 0;
    sawSetup = 1'b0;
    while (!rsp_valid && edges < 300) begin
      if (PSEL && !PENABLE) sawSetup = 1'b1;
      if (PSEL && PENABLE) accessCycles++;
      @(negedge PCLK);
      edges++;
    end
    rdata = rsp_rdata;
    checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_psel_low"}, 64'(PSEL), 64'd0);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      checkOutput({tag, "_err"}, 64'(rsp_err), 64'(e.err));
      checkOutput({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.tmo));
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int edges, acc, got, sent, cyc, seen, n;
    logic setup;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d0, d1;

    PRESETn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < MEMSZ; i++) refMem[i] = DW'(i);

    // Reset values
    repeat (3) @(negedge PCLK);
    memLoad = 1'b0;
    checkOutput("rst_psel", 64'(PSEL), 64'd0);
    checkOutput("rst_penable", 64'(PENABLE), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_paddr", 64'(PADDR), 64'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Read address 5: four-edge latency, one SETUP then one ACCESS
    applyStimulus(1'b0, 32'd5, '0);
    collectResponse("rd5", edges, acc, setup, rd);
    checkOutput("rd5_latency", 64'(edges), 64'd4);
    checkOutput("rd5_setup_seen", 64'(setup), 64'd1);
    checkOutput("rd5_access_cycles", 64'(acc), 64'd1);
    checkOutput("rd5_value", 64'(rd), 64'd5);

    // Write then read back address 10
    applyStimulus(1'b1, 32'd10, 32'hDEADBEEF);
    collectResponse("wr10", edges, acc, setup, rd);
    checkOutput("wr10_rdata_zero", 64'(rd), 64'd0);
    applyStimulus(1'b0, 32'd10, '0);
    collectResponse("rd10", edges, acc, setup, rd);
    checkOutput("rd10_value", 64'(rd), 64'hDEADBEEF);

    // Out-of-range read gives a slave error
    applyStimulus(1'b0, 32'd1024, '0);
    collectResponse("rd1024", edges, acc, setup, rd);

    // Hung slave: abort after 16 ACCESS cycles
    hangMode = 1'b1;
    applyStimulus(1'b0, 32'd3, '0);
    collectResponse("hang", edges, acc, setup, rd);
    checkOutput("hang_access_cycles", 64'(acc), 64'd16);
    hangMode = 1'b0;

    // Five back-to-back commands with responses stalled
    d0 = $urandom;
    d1 = $urandom;
    applyStimulus(1'b1, 32'd20, d0);
    applyStimulus(1'b1, 32'd21, d1);
    applyStimulus(1'b0, 32'd20, '0);
    applyStimulus(1'b0, 32'd21, '0);
    applyStimulus(1'b0, 32'd22, '0);
    checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (6) @(negedge PCLK);
    checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
    checkOutput("hold_rdata", 64'(rsp_rdata), 64'(expQ[0].rdata));
    for (int k = 0; k < 5; k++) collectResponse("burst", edges, acc, setup, rd);
    checkOutput("burst_last_rdata", 64'(rd), 64'd22);

    // Reset during ACCESS with three commands queued
    hangMode = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'd7 + 32'(k), 32'hA5A5_0000 + 32'(k));
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput("mid_in_access", 64'(PSEL && PENABLE), 64'd1);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_psel", 64'(PSEL), 64'd0);
    checkOutput("mid_rst_penable", 64'(PENABLE), 64'd0);
    checkOutput("mid_rst_pwrite", 64'(PWRITE), 64'd0);
    checkOutput("mid_rst_paddr", 64'(PADDR), 64'd0);
    checkOutput("mid_rst_pwdata", 64'(PWDATA), 64'd0);
    checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    expQ.delete();
    hangMode = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen++;
    end
    checkOutput("post_rst_quiet", 64'(seen), 64'd0);

    // Randomized traffic with random wait states and response back-pressure
    got = 0;
    sent = 0;
    cyc = 0;
    while (got < 40 && cyc < 4000) begin
      if (PSEL && !PENABLE) slaveWaits = $urandom_range(0, 3);
      if (rsp_valid && ($urandom % 3 != 0)) begin
        rsp_t e;
        if (expQ.size() == 0) begin
          checkOutput("rand_unexpected", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rand_rdata", 64'(rsp_rdata), 64'(e.rdata));
          checkOutput("rand_err", 64'(rsp_err), 64'(e.err));
          checkOutput("rand_timeout", 64'(rsp_timeout), 64'(e.tmo));
        end
        rsp_ready = 1'b1;
        got++;
      end else begin
        rsp_ready = 1'b0;
      end
      if (sent < 40 && cmd_ready && ($urandom % 2 == 1)) begin
        a = ($urandom % 8 == 0) ? 32'd1020 + 32'($urandom % 8) : 32'($urandom % 16);
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom % 2);
        cmd_addr  = a;
        cmd_wdata = $urandom;
        modelPush(cmd_write, cmd_addr, cmd_wdata);
        sent++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge PCLK);
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("rand_all_done", 64'(got), 64'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
